// File: rtl/core_frontend.sv
// core_frontend: instruction-fetch front end with a valid/ready request/response
// port to instruction memory and a DEPTH-entry prefetch queue feeding the IDU.
//
// At most one fetch request is in flight. Redirects flush the queue and restart
// fetch at a new PC. A response that belongs to a superseded request is dropped
// through the discard flag. A fault response, or a misaligned redirect target,
// enqueues a single fault entry and stops fetching until the next redirect.
// halt (ebreak) stops fetching. It waits for any in-flight response and then
// parks in HALTED until rst.
//
// Ports:
//   clk, rst         core clock, synchronous active-high reset
//   imem_req_*       fetch request (valid/ready/addr)
//   imem_rsp_*       fetch response (valid/data/err), always accepted
//   dec_*            queue head to the IDU (valid/ready/inst/pc/fault)
//   redirect_*       flush and refetch from redirect_pc
//   halt / halted    level halt request / frontend parked
//   occupancy        number of valid queue entries

module core_frontend #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       imem_rsp_err,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [31:0]                dec_inst,
  output logic [XLEN-1:0]            dec_pc,
  output logic                       dec_fault,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       halt,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_STALL  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [AW-1:0]   PTR_ZERO = AW'(0);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic [1:0]      state_r;
  logic [1:0]      state_n_s;
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] req_pc_r;       // address of the in-flight request
  logic            outstanding_r;
  logic            discard_r;      // in-flight response belongs to a flushed stream

  logic [31:0]     inst_mem_r  [DEPTH];
  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic            fault_mem_r [DEPTH];
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;

  logic [CW-1:0]   inflight_s;
  logic            req_fire_s;
  logic            rsp_fire_s;
  logic            redir_s;
  logic            misalign_s;
  logic            push_s;
  logic            push_fault_s;
  logic            pop_s;

  // Queued entries plus the in-flight one must fit, so a response can never overflow.
  assign inflight_s = count_r + {{(CW-1){1'b0}}, outstanding_r};

  assign imem_req_valid = !rst && (state_r == ST_RUN) && !outstanding_r &&
                          (inflight_s < DEPTH_C) && !halt && !redirect_valid;
  assign imem_req_addr  = fetch_pc_r;

  assign req_fire_s   = imem_req_valid && imem_req_ready;
  assign rsp_fire_s   = imem_rsp_valid && outstanding_r;
  assign redir_s      = redirect_valid && (state_r != ST_HALTED);
  assign misalign_s   = (redirect_pc[1:0] != 2'b00);
  // A redirect wins over any push or pop in the same cycle.
  assign push_s       = rsp_fire_s && !discard_r && !redir_s;
  assign push_fault_s = push_s && imem_rsp_err;
  assign pop_s        = dec_valid && dec_ready && !redir_s;

  assign dec_valid = (count_r != {CW{1'b0}});
  assign dec_inst  = inst_mem_r[rd_ptr_r];
  assign dec_pc    = pc_mem_r[rd_ptr_r];
  assign dec_fault = fault_mem_r[rd_ptr_r];
  assign halted    = (state_r == ST_HALTED);
  assign occupancy = count_r;

  // Next-state selection for the fetch control FSM.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_RUN, ST_STALL: begin
        if (halt) begin
          // A response landing this very cycle means nothing is left to wait for.
          if (outstanding_r && !rsp_fire_s) begin
            state_n_s = ST_DRAIN;
          end else begin
            state_n_s = ST_HALTED;
          end
        end else if (redir_s) begin
          state_n_s = misalign_s ? ST_STALL : ST_RUN;
        end else if (push_fault_s) begin
          state_n_s = ST_STALL;
        end else begin
          state_n_s = state_r;
        end
      end
      ST_DRAIN: begin
        if (rsp_fire_s) begin
          state_n_s = ST_HALTED;
        end else begin
          state_n_s = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        state_n_s = ST_HALTED;
      end
      default: begin
        state_n_s = ST_RUN;
      end
    endcase
  end

  // Fetch control state: FSM, fetch PC, in-flight tracking and discard flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RUN;
      fetch_pc_r    <= RESET_PC;
      req_pc_r      <= {XLEN{1'b0}};
      outstanding_r <= 1'b0;
      discard_r     <= 1'b0;
    end else begin
      state_r <= state_n_s;

      if (redir_s) begin
        fetch_pc_r <= redirect_pc;
      end else if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end

      if (req_fire_s) begin
        outstanding_r <= 1'b1;
        req_pc_r      <= fetch_pc_r;
      end else if (rsp_fire_s) begin
        outstanding_r <= 1'b0;
      end else begin
        outstanding_r <= outstanding_r;
      end

      // A response arriving with the redirect is dropped by push_s directly,
      // so only a still-pending request needs the flag.
      if (redir_s) begin
        discard_r <= (outstanding_r && !rsp_fire_s) || req_fire_s;
      end else if (rsp_fire_s && discard_r) begin
        discard_r <= 1'b0;
      end else begin
        discard_r <= discard_r;
      end
    end
  end

  // Prefetch queue storage, pointers and entry count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_r[i]  <= 32'h0;
        pc_mem_r[i]    <= {XLEN{1'b0}};
        fault_mem_r[i] <= 1'b0;
      end
    end else if (redir_s) begin
      rd_ptr_r <= PTR_ZERO;
      if (misalign_s) begin
        // A misaligned target becomes a single fault entry instead of a fetch.
        inst_mem_r[0]  <= 32'h0;
        pc_mem_r[0]    <= redirect_pc;
        fault_mem_r[0] <= 1'b1;
        wr_ptr_r       <= PTR_ONE;
        count_r        <= CNT_ONE;
      end else begin
        wr_ptr_r <= PTR_ZERO;
        count_r  <= {CW{1'b0}};
      end
    end else begin
      if (push_s) begin
        inst_mem_r[wr_ptr_r]  <= imem_rsp_err ? 32'h0 : imem_rsp_data;
        pc_mem_r[wr_ptr_r]    <= req_pc_r;
        fault_mem_r[wr_ptr_r] <= imem_rsp_err;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end

      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end

      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  core_frontend_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk            (clk),
    .rst            (rst),
    .imem_rsp_valid (imem_rsp_valid),
    .outstanding    (outstanding_r),
    .occupancy      (count_r)
  );

endmodule

// core_frontend_chk: protocol and invariant properties for core_frontend.
// Ports: clk, rst, imem_rsp_valid, outstanding (request in flight), occupancy.
module core_frontend_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          imem_rsp_valid,
  input logic          outstanding,
  input logic [CW-1:0] occupancy
);

  // Memory must never answer when no request is in flight.
  rsp_has_req: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> outstanding);

  // The issue rule keeps the queue from overflowing.
  occ_bounded: assert property (@(posedge clk) disable iff (rst)
    occupancy <= CW'(DEPTH));

endmodule

// File: tb/tb_core_frontend.sv
module tb_core_frontend;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_fault;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        halted;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  core_frontend #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_fault(dec_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted), .occupancy(occupancy)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; logic fault; } ent_t;
  typedef struct {
    logic        dec_ready;
    logic        req_ready;
    int          n;
    logic [2:0]  exp_occ;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
  } vec_t;

  ent_t        exp_q[$];
  int          n_checks = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          rsp_at = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] rsp_addr = 32'h0;
  logic [31:0] err_addr = 32'h0;
  logic        tb_out = 1'b0;
  logic        tb_disc = 1'b0;
  logic        exp_halted = 1'b0;
  logic [31:0] exp_fpc = RESET_PC;
  logic        fired = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: memory model drives, outputs checked at negedge, scoreboard updated.
  task automatic cycle();
    ent_t e;
    logic redir_eff;
    logic fire_now;
    if (pend && cyc >= rsp_at) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(pend_addr);
      imem_rsp_err   = (pend_addr == err_addr);
      rsp_addr       = pend_addr;
      pend           = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_rsp_err   = 1'b0;
    end
    @(negedge clk);
    check("occupancy", 32'(occupancy), exp_q.size());
    check("dec_valid", 32'(dec_valid), 32'(exp_q.size() != 0));
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_fpc);
    redir_eff = redirect_valid && !exp_halted;
    fire_now  = imem_req_valid && imem_req_ready;
    if (dec_valid && dec_ready && exp_q.size() != 0) begin
      e = exp_q[0];
      check("head_pc", dec_pc, e.pc);
      check("head_inst", dec_inst, e.inst);
      check("head_fault", 32'(dec_fault), 32'(e.fault));
      if (!redir_eff) void'(exp_q.pop_front());
    end
    if (redir_eff) begin
      exp_q.delete();
      if (redirect_pc[1:0] != 2'b00) exp_q.push_back('{redirect_pc, 32'h0, 1'b1});
    end else if (imem_rsp_valid && !tb_disc) begin
      exp_q.push_back('{rsp_addr, imem_rsp_err ? 32'h0 : imem_rsp_data, imem_rsp_err});
    end
    if (redir_eff) tb_disc = (tb_out && !imem_rsp_valid) || fire_now;
    else if (imem_rsp_valid && tb_disc) tb_disc = 1'b0;
    if (fire_now) tb_out = 1'b1;
    else if (imem_rsp_valid) tb_out = 1'b0;
    if (redir_eff) exp_fpc = redirect_pc;
    else if (fire_now) exp_fpc = exp_fpc + 32'd4;
    if (fire_now) begin
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      rsp_at    = cyc + lat;
      fired     = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_req_ready = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; halt = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_rsp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; pend = 1'b0; tb_out = 1'b0; tb_disc = 1'b0; exp_halted = 1'b0;
    exp_fpc = RESET_PC; exp_q.delete(); cyc = 0; lat = 1; err_addr = 32'h0; fired = 1'b0;
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_occ"}, 32'(occupancy), 32'd0);
    check({tag, "_dec_valid"}, 32'(dec_valid), 32'd0);
    check({tag, "_dec_inst"}, dec_inst, 32'h0);
    check({tag, "_dec_pc"}, dec_pc, 32'h0);
    check({tag, "_dec_fault"}, 32'(dec_fault), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd1);
    check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
  endtask

  task automatic wait_fire(input string name);
    fired = 1'b0;
    for (int i = 0; i < 40 && !fired; i++) cycle();
    check(name, 32'(fired), 32'd1);
  endtask

  task automatic wait_head(input string name, input logic [31:0] pc);
    for (int i = 0; i < 40 && !dec_valid; i++) cycle();
    check({name, "_valid"}, 32'(dec_valid), 32'd1);
    check({name, "_pc"}, dec_pc, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    tbl[0] = '{1'b1, 1'b1, 6,  3'd1, 1'b1, 32'h8000_000C};
    tbl[1] = '{1'b0, 1'b1, 12, 3'd4, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1,  3'd3, 1'b1, 32'h8000_0018};
    tbl[3] = '{1'b0, 1'b1, 4,  3'd4, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 8,  3'd0, 1'b1, 32'h8000_001C};

    do_reset();
    check_reset_state("reset");

    // Basic streaming, queue fill with dec_ready low, single pop pulse, drain.
    for (int k = 0; k < 5; k++) begin
      dec_ready      = tbl[k].dec_ready;
      imem_req_ready = tbl[k].req_ready;
      for (int j = 0; j < tbl[k].n; j++) cycle();
      check($sformatf("vec%0d_occ", k), 32'(occupancy), 32'(tbl[k].exp_occ));
      check($sformatf("vec%0d_req_valid", k), 32'(imem_req_valid), 32'(tbl[k].exp_req_valid));
      if (tbl[k].exp_req_valid) check($sformatf("vec%0d_req_addr", k), imem_req_addr, tbl[k].exp_addr);
    end

    // Request held stable while memory is not ready, accepted on the sixth cycle.
    fired = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check("hold_valid", 32'(imem_req_valid), 32'd1);
      check("hold_addr", imem_req_addr, 32'h8000_001C);
      cycle();
    end
    check("hold_no_accept", 32'(fired), 32'd0);
    imem_req_ready = 1'b1;
    cycle();
    check("hold_accept", 32'(fired), 32'd1);

    // Redirect in the same cycle as the response: response dropped.
    wait_fire("fire_a");
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("redir_same_flush", 32'(occupancy), 32'd0);
    wait_head("redir_same", 32'h8000_0300);

    // Redirect with a slow response outstanding: late response discarded.
    lat = 3;
    wait_fire("fire_b");
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("redir_slow_dec_valid", 32'(dec_valid), 32'd0);
    wait_head("redir_slow", 32'h8000_0100);

    // Fetch fault stops fetching until a redirect.
    lat = 1;
    err_addr = 32'h8000_0108;
    for (int i = 0; i < 40 && !(dec_valid && dec_fault); i++) cycle();
    check("fault_pc", dec_pc, 32'h8000_0108);
    check("fault_inst", dec_inst, 32'h0);
    check("fault_flag", 32'(dec_fault), 32'd1);
    err_addr = 32'h0;
    for (int j = 0; j < 6; j++) begin
      check("stall_no_req", 32'(imem_req_valid), 32'd0);
      cycle();
    end

    // Misaligned redirect: one fault entry, still no fetch.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("misalign_pc", dec_pc, 32'h8000_0102);
    check("misalign_fault", 32'(dec_fault), 32'd1);
    check("misalign_inst", dec_inst, 32'h0);
    for (int j = 0; j < 5; j++) begin
      check("misalign_no_req", 32'(imem_req_valid), 32'd0);
      cycle();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("resume_req_valid", 32'(imem_req_valid), 32'd1);
    check("resume_req_addr", imem_req_addr, 32'h8000_0200);

    // Halt with a request outstanding: DRAIN, then HALTED after the response.
    dec_ready = 1'b0;
    lat = 2;
    wait_fire("fire_h1");
    wait_fire("fire_h2");
    halt = 1'b1;
    cycle();
    check("drain_halted", 32'(halted), 32'd0);
    check("drain_no_req", 32'(imem_req_valid), 32'd0);
    cycle();
    check("halted_set", 32'(halted), 32'd1);
    check("halted_occ", 32'(occupancy), 32'd2);
    exp_halted = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("halt_redir_occ", 32'(occupancy), 32'd2);
    check("halt_redir_req", 32'(imem_req_valid), 32'd0);
    check("halt_redir_halted", 32'(halted), 32'd1);
    dec_ready = 1'b1;
    cycle();
    dec_ready = 1'b0;
    #1;
    check("halt_pop_occ", 32'(occupancy), 32'd1);
    check("halt_pop_next_pc", dec_pc, 32'h8000_0204);

    // Reset with an entry still queued returns to the reset fetch address.
    do_reset();
    check_reset_state("rereset");

    // Halt with nothing outstanding goes straight to HALTED.
    halt = 1'b1;
    #1;
    check("halt_idle_no_req", 32'(imem_req_valid), 32'd0);
    cycle();
    check("halt_idle_halted", 32'(halted), 32'd1);
    halt = 1'b0;
    cycle();
    check("halt_idle_sticky", 32'(halted), 32'd1);
    check("halt_idle_sticky_req", 32'(imem_req_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
